cvxif_issue_tracker: RTL and testbench
======================================

Name: cvxif_issue_tracker

Overview:
- Coprocessor-side front end of the CV-X-IF, directly downstream of the issue, register and commit channels.
- Holds each accepted offloaded instruction in an in-order queue of DEPTH entries.
- Attaches the instruction's source operands from the register channel and waits for its commit or kill.
- Dispatches committed, operand-complete instructions in issue order to the coprocessor execution unit; killed instructions are dropped silently.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
X_ID_WIDTH, 4, width of instruction id
X_HARTID_WIDTH, 1, width of hartid
X_NUM_RS, 2, source operands per instruction
X_RFR_WIDTH, 32, operand width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
issue_valid_i  in  1  core offers instruction
issue_ready_o  out  1  tracker can take issue transaction
issue_accept_i  in  1  local decoder accepts issue_instr_i (combinational)
issue_instr_i  in  32  instruction
issue_id_i  in  X_ID_WIDTH  instruction id
issue_hartid_i  in  X_HARTID_WIDTH  hart id
register_valid_i  in  1  operand transaction valid
register_ready_o  out  1  operands captured this cycle
register_id_i  in  X_ID_WIDTH  id the operands belong to
register_hartid_i  in  X_HARTID_WIDTH  hart id
register_rs_i  in  X_NUM_RS*X_RFR_WIDTH  operands, rs[0] in LSBs
register_rs_valid_i  in  X_NUM_RS  per-operand validity
commit_valid_i  in  1  commit transaction
commit_id_i  in  X_ID_WIDTH  committed id
commit_hartid_i  in  X_HARTID_WIDTH  hart id
commit_kill_i  in  1  1 = kill, 0 = commit
ex_valid_o  out  1  dispatch valid
ex_ready_i  in  1  execution unit ready
ex_instr_o  out  32  dispatched instruction
ex_id_o  out  X_ID_WIDTH  dispatched id
ex_hartid_o  out  X_HARTID_WIDTH  dispatched hart
ex_rs_o  out  X_NUM_RS*X_RFR_WIDTH  dispatched operands
occupancy_o  out  $clog2(DEPTH)+1  allocated entries
error_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): all entries invalid, pointers 0, occupancy_o=0, error_o=0. ex_valid_o, ex_*, register_ready_o are 0. issue_ready_o=1 when issue_accept_i=0, and 0 otherwise (nothing in flight, queue empty). Reset mid-operation discards all entries without dispatch.
- Entry state: valid, instr, id, hartid, ops, opnd_ok, committed, killed.
- Issue:
  - issue_ready_o = !issue_accept_i | (!full & !id_busy).
  - id_busy = a valid, non-killed entry holds the same {hartid,id}.
  - Allocation at the tail when issue_valid_i & issue_ready_o & issue_accept_i.
  - A rejected instruction (accept=0) completes its handshake with no allocation.
  - A pop in the same cycle does not free space for allocation when full; issue_ready_o is based on registered full.
- Register channel:
  - CAM match on {hartid,id} against entries that are valid, !opnd_ok and !killed.
  - register_ready_o = register_valid_i & match & (&register_rs_valid_i). Ops are captured and opnd_ok is set on the next edge.
  - Partial rs_valid: ready stays 0 and the core holds.
  - register_valid_i with no match: ready stays 0 and error_o is set. This includes an id allocated in the same cycle, since a new entry is visible only from the next cycle.
- Commit channel:
  - Single-cycle, no ready. CAM match on {hartid,id} against valid entries that are !committed & !killed.
  - Match with kill=0 sets committed; kill=1 sets killed. No match sets error_o and the transaction is otherwise ignored.
  - Commit and register may hit the same entry in the same cycle; both take effect.
- Dispatch:
  - ex_valid_o = head.valid & head.committed & head.opnd_ok & !head.killed. ex_* are driven from head storage, with no added latency beyond storage.
  - Head pops on ex_valid_o & ex_ready_i.
  - A killed head pops without ex_valid_o, one entry per cycle, whether or not its operands arrived.
  - ex_* stay stable while ex_valid_o=1 and ex_ready_i=0.
  - Minimum latency: issue at cycle 0, register and commit at cycle 1, ex_valid_o at cycle 2.
- Pointers wrap modulo DEPTH. occupancy_o updates by +1 on allocation and -1 on pop; simultaneous allocation and pop leaves it unchanged.
- error_o is cleared only by reset.

Test Plan:
- Basic flow: issue id=3, instr=0x0000_000B, accept=1. Cycle 1: register id=3, rs=0x11/0x22, rs_valid=2'b11, and commit id=3, kill=0. Required: ex_valid_o at cycle 2 with id=3, ex_rs_o={0x22,0x11}, occupancy_o 1 -> 0 after ex handshake.
- Kill: issue ids 1 and 2; commit id=1 kill=1 before its operands arrive; register and commit id=2. Required: id 1 popped with no ex_valid_o, id 2 dispatched next, error_o=0.
- Full queue: issue 4 accepted ids 0-3 with ex_ready_i=0. Required: issue_ready_o=0 for a 5th accepted issue; issue_ready_o=1 for accept=0; after one dispatch, the 5th is taken the following cycle.
- Backpressure and wrap: 10 back-to-back instructions with ex_ready_i toggling every cycle. Required: in-order ids 0-9 dispatched, ex_* stable while stalled, pointer wrap correct.
- Errors: commit id=7 never issued, and register with rs_valid=2'b01. Required: error_o=1 after the stray commit; register_ready_o=0 while partial.
- Reset mid-operation: with 3 entries pending, pulse rst_ni=0 for one cycle. Required: occupancy_o=0, ex_valid_o=0, error_o=0, and no dispatch of the pending ids.

Source files
------------

// File: rtl/cvxif_issue_tracker.sv
// cvxif_issue_tracker
//   Coprocessor-side front end for the CV-X-IF. Accepted offloaded
//   instructions enter an in-order queue of DEPTH entries. Each entry collects
//   its source operands from the register channel and its commit or kill from
//   the commit channel. Committed, operand-complete entries are dispatched to
//   the execution unit in issue order. Killed entries are dropped without
//   dispatch.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   issue_*                issue channel; issue_accept_i comes from the local decoder
//   register_*             operand channel; rs[0] sits in the LSBs of register_rs_i
//   commit_*               commit/kill channel (single cycle, no ready)
//   ex_*                   dispatch to the execution unit (valid/ready)
//   occupancy_o            number of allocated entries
//   error_o                sticky protocol error (unmatched register or commit)
module cvxif_issue_tracker #(
  parameter int DEPTH          = 4,
  parameter int X_ID_WIDTH     = 4,
  parameter int X_HARTID_WIDTH = 1,
  parameter int X_NUM_RS       = 2,
  parameter int X_RFR_WIDTH    = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic                            issue_accept_i,
  input  logic [31:0]                     issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]           issue_id_i,
  input  logic [X_HARTID_WIDTH-1:0]       issue_hartid_i,
  input  logic                            register_valid_i,
  output logic                            register_ready_o,
  input  logic [X_ID_WIDTH-1:0]           register_id_i,
  input  logic [X_HARTID_WIDTH-1:0]       register_hartid_i,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] register_rs_i,
  input  logic [X_NUM_RS-1:0]             register_rs_valid_i,
  input  logic                            commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]           commit_id_i,
  input  logic [X_HARTID_WIDTH-1:0]       commit_hartid_i,
  input  logic                            commit_kill_i,
  output logic                            ex_valid_o,
  input  logic                            ex_ready_i,
  output logic [31:0]                     ex_instr_o,
  output logic [X_ID_WIDTH-1:0]           ex_id_o,
  output logic [X_HARTID_WIDTH-1:0]       ex_hartid_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] ex_rs_o,
  output logic [$clog2(DEPTH):0]          occupancy_o,
  output logic                            error_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OPS_W = X_NUM_RS * X_RFR_WIDTH;

  logic [DEPTH-1:0]          valid_q, committed_q, killed_q, opnd_ok_q;
  logic [31:0]               instr_q  [DEPTH];
  logic [X_ID_WIDTH-1:0]     id_q     [DEPTH];
  logic [X_HARTID_WIDTH-1:0] hartid_q [DEPTH];
  logic [OPS_W-1:0]          ops_q    [DEPTH];
  logic [PTR_W-1:0]          head_q, tail_q;
  logic [CNT_W-1:0]          occ_q;
  logic                      error_q;

  logic             id_busy, reg_hit, cmt_hit;
  logic [PTR_W-1:0] reg_idx, cmt_idx;
  logic             full, alloc, pop, head_drop;

  // {hartid,id} lookups. Killed entries are invisible to all three searches,
  // so a killed entry still draining can share its id with a newer one.
  always_comb begin
    id_busy = 1'b0;
    reg_hit = 1'b0;
    reg_idx = '0;
    cmt_hit = 1'b0;
    cmt_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !killed_q[i] &&
          id_q[i] == issue_id_i && hartid_q[i] == issue_hartid_i)
        id_busy = 1'b1;
      if (valid_q[i] && !killed_q[i] && !opnd_ok_q[i] &&
          id_q[i] == register_id_i && hartid_q[i] == register_hartid_i) begin
        reg_hit = 1'b1;
        reg_idx = PTR_W'(i);
      end
      if (valid_q[i] && !killed_q[i] && !committed_q[i] &&
          id_q[i] == commit_id_i && hartid_q[i] == commit_hartid_i) begin
        cmt_hit = 1'b1;
        cmt_idx = PTR_W'(i);
      end
    end
  end

  // Space is judged on registered occupancy; a same-cycle pop does not help.
  assign full          = (occ_q == CNT_W'(DEPTH));
  assign issue_ready_o = !issue_accept_i | (rst_ni & !full & !id_busy);
  assign alloc         = issue_valid_i & issue_ready_o & issue_accept_i;

  assign register_ready_o = rst_ni & register_valid_i & reg_hit & (&register_rs_valid_i);

  assign ex_valid_o = rst_ni & valid_q[head_q] & committed_q[head_q] &
                      opnd_ok_q[head_q] & !killed_q[head_q];
  assign head_drop  = valid_q[head_q] & killed_q[head_q];
  assign pop        = (ex_valid_o & ex_ready_i) | head_drop;

  assign ex_instr_o  = ex_valid_o ? instr_q[head_q]  : '0;
  assign ex_id_o     = ex_valid_o ? id_q[head_q]     : '0;
  assign ex_hartid_o = ex_valid_o ? hartid_q[head_q] : '0;
  assign ex_rs_o     = ex_valid_o ? ops_q[head_q]    : '0;
  assign occupancy_o = occ_q;
  assign error_o     = error_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      opnd_ok_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      error_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]  <= '0;
        id_q[i]     <= '0;
        hartid_q[i] <= '0;
        ops_q[i]    <= '0;
      end
    end else begin
      if (pop) begin
        valid_q[head_q]     <= 1'b0;
        committed_q[head_q] <= 1'b0;
        killed_q[head_q]    <= 1'b0;
        opnd_ok_q[head_q]   <= 1'b0;
        head_q              <= head_q + PTR_W'(1);
      end
      // Tail never equals a valid head here: alloc needs !full.
      if (alloc) begin
        valid_q[tail_q]     <= 1'b1;
        committed_q[tail_q] <= 1'b0;
        killed_q[tail_q]    <= 1'b0;
        opnd_ok_q[tail_q]   <= 1'b0;
        instr_q[tail_q]     <= issue_instr_i;
        id_q[tail_q]        <= issue_id_i;
        hartid_q[tail_q]    <= issue_hartid_i;
        tail_q              <= tail_q + PTR_W'(1);
      end
      if (register_ready_o) begin
        ops_q[reg_idx]     <= register_rs_i;
        opnd_ok_q[reg_idx] <= 1'b1;
      end
      if (commit_valid_i && cmt_hit) begin
        if (commit_kill_i) killed_q[cmt_idx]    <= 1'b1;
        else               committed_q[cmt_idx] <= 1'b1;
      end
      if ((register_valid_i && !reg_hit) || (commit_valid_i && !cmt_hit))
        error_q <= 1'b1;
      if (alloc && !pop)      occ_q <= occ_q + CNT_W'(1);
      else if (!alloc && pop) occ_q <= occ_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cvxif_issue_tracker.sv
module tb_cvxif_issue_tracker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i, issue_ready_o, issue_accept_i;
  logic [31:0] issue_instr_i;
  logic [3:0]  issue_id_i;
  logic [0:0]  issue_hartid_i;
  logic        register_valid_i, register_ready_o;
  logic [3:0]  register_id_i;
  logic [0:0]  register_hartid_i;
  logic [63:0] register_rs_i;
  logic [1:0]  register_rs_valid_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic [0:0]  commit_hartid_i;
  logic        commit_kill_i;
  logic        ex_valid_o, ex_ready_i;
  logic [31:0] ex_instr_o;
  logic [3:0]  ex_id_o;
  logic [0:0]  ex_hartid_o;
  logic [63:0] ex_rs_o;
  logic [2:0]  occupancy_o;
  logic        error_o;

  int n_vec = 0;
  int n_err = 0;

  cvxif_issue_tracker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_accept_i(issue_accept_i), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_hartid_i(issue_hartid_i),
    .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
    .register_id_i(register_id_i), .register_hartid_i(register_hartid_i),
    .register_rs_i(register_rs_i), .register_rs_valid_i(register_rs_valid_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_hartid_i(commit_hartid_i), .commit_kill_i(commit_kill_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_instr_o(ex_instr_o), .ex_id_o(ex_id_o), .ex_hartid_o(ex_hartid_o),
    .ex_rs_o(ex_rs_o), .occupancy_o(occupancy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i       = 1'b0;
    issue_accept_i      = 1'b1;
    issue_instr_i       = '0;
    issue_id_i          = '0;
    issue_hartid_i      = '0;
    register_valid_i    = 1'b0;
    register_id_i       = '0;
    register_hartid_i   = '0;
    register_rs_i       = '0;
    register_rs_valid_i = 2'b11;
    commit_valid_i      = 1'b0;
    commit_id_i         = '0;
    commit_hartid_i     = '0;
    commit_kill_i       = 1'b0;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] instr);
    issue_valid_i = 1'b1; issue_accept_i = 1'b1;
    issue_id_i = id; issue_instr_i = instr;
  endtask

  task automatic reg_cmt(input logic [3:0] id);
    register_valid_i = 1'b1; register_id_i = id;
    register_rs_i = {28'h0, id, 32'h100 + 32'(id)};
    register_rs_valid_i = 2'b11;
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    ex_ready_i = 1'b1;
    while (occupancy_o != 0 && k < 50) begin cyc(); k++; end
    chk(tag, 64'(occupancy_o), 64'd0);
  endtask

  initial begin
    logic [3:0]  exp_id, last_id;
    logic [31:0] save_instr;
    logic [63:0] save_rs;
    logic        prev_stall, prev_alloc;
    int          nxt, budget;

    idle();
    ex_ready_i = 1'b0;
    rst_ni = 1'b0;
    issue_accept_i = 1'b0;
    #1;
    chk("rst_ready_noaccept", 64'(issue_ready_o), 64'd1);
    issue_accept_i = 1'b1;
    cyc(); cyc();
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_err", 64'(error_o), 64'd0);
    chk("rst_exv", 64'(ex_valid_o), 64'd0);
    chk("rst_regrdy", 64'(register_ready_o), 64'd0);
    rst_ni = 1'b1;
    #1;
    chk("idle_ready", 64'(issue_ready_o), 64'd1);

    // basic flow
    issue(4'd3, 32'h0000_000B);
    #1 chk("basic_issue_rdy", 64'(issue_ready_o), 64'd1);
    cyc(); idle();
    chk("basic_occ1", 64'(occupancy_o), 64'd1);
    register_valid_i = 1'b1; register_id_i = 4'd3;
    register_rs_i = {32'h22, 32'h11}; register_rs_valid_i = 2'b11;
    commit_valid_i = 1'b1; commit_id_i = 4'd3;
    #1;
    chk("basic_regrdy", 64'(register_ready_o), 64'd1);
    chk("basic_exv_c1", 64'(ex_valid_o), 64'd0);
    cyc(); idle();
    chk("basic_exv_c2", 64'(ex_valid_o), 64'd1);
    chk("basic_id", 64'(ex_id_o), 64'd3);
    chk("basic_instr", 64'(ex_instr_o), 64'h0000_000B);
    chk("basic_rs", ex_rs_o, 64'h0000_0022_0000_0011);
    ex_ready_i = 1'b1;
    cyc();
    chk("basic_occ0", 64'(occupancy_o), 64'd0);
    chk("basic_exv_done", 64'(ex_valid_o), 64'd0);

    // kill
    issue(4'd1, 32'hA1); cyc();
    issue(4'd2, 32'hA2); cyc(); idle();
    commit_valid_i = 1'b1; commit_id_i = 4'd1; commit_kill_i = 1'b1;
    cyc(); idle();
    reg_cmt(4'd2);
    #1;
    chk("kill_head_exv", 64'(ex_valid_o), 64'd0);
    chk("kill_occ2", 64'(occupancy_o), 64'd2);
    cyc(); idle();
    chk("kill_next_exv", 64'(ex_valid_o), 64'd1);
    chk("kill_next_id", 64'(ex_id_o), 64'd2);
    chk("kill_occ1", 64'(occupancy_o), 64'd1);
    cyc();
    chk("kill_occ0", 64'(occupancy_o), 64'd0);
    chk("kill_err", 64'(error_o), 64'd0);

    // full queue
    ex_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 32'h100 + 32'(i)); cyc();
    end
    chk("full_occ4", 64'(occupancy_o), 64'd4);
    issue(4'd4, 32'h104);
    #1 chk("full_rdy_acc", 64'(issue_ready_o), 64'd0);
    issue_accept_i = 1'b0;
    #1 chk("full_rdy_noacc", 64'(issue_ready_o), 64'd1);
    cyc(); idle();
    chk("full_reject_occ", 64'(occupancy_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      reg_cmt(4'(i)); cyc();
    end
    idle();
    chk("full_head_id", 64'(ex_id_o), 64'd0);
    ex_ready_i = 1'b1;
    issue(4'd4, 32'h104);
    #1 chk("full_pop_same_cyc", 64'(issue_ready_o), 64'd0);
    cyc();
    chk("full_occ3", 64'(occupancy_o), 64'd3);
    chk("full_rdy_after", 64'(issue_ready_o), 64'd1);
    cyc(); idle();
    chk("full_occ3b", 64'(occupancy_o), 64'd3);
    chk("full_id2", 64'(ex_id_o), 64'd2);
    reg_cmt(4'd4); cyc(); idle();
    drain("full_drain");

    // backpressure and wrap
    nxt = 0; exp_id = 0; prev_stall = 0; prev_alloc = 0; last_id = 0;
    save_instr = 0; save_rs = 0; budget = 0;
    while (exp_id != 4'd10 && budget < 200) begin
      idle();
      ex_ready_i = budget[0];
      if (prev_alloc) reg_cmt(last_id);
      if (nxt < 10) issue(4'(nxt), 32'h1000 + 32'(nxt));
      #1;
      if (prev_alloc) chk("bp_regrdy", 64'(register_ready_o), 64'd1);
      prev_alloc = issue_valid_i & issue_ready_o;
      if (prev_alloc) begin last_id = 4'(nxt); nxt++; end
      if (prev_stall) begin
        chk("bp_stall_valid", 64'(ex_valid_o), 64'd1);
        chk("bp_stall_instr", 64'(ex_instr_o), 64'(save_instr));
        chk("bp_stall_rs", ex_rs_o, save_rs);
      end
      if (ex_valid_o) begin
        chk("bp_order_id", 64'(ex_id_o), 64'(exp_id));
        chk("bp_instr", 64'(ex_instr_o), 64'h1000 + 64'(exp_id));
        chk("bp_rs", ex_rs_o, {28'h0, exp_id, 32'h100 + 32'(exp_id)});
        if (ex_ready_i) exp_id++;
      end
      prev_stall = ex_valid_o & !ex_ready_i;
      save_instr = ex_instr_o;
      save_rs = ex_rs_o;
      cyc();
      budget++;
    end
    idle();
    chk("bp_all_dispatched", 64'(exp_id), 64'd10);
    chk("bp_occ0", 64'(occupancy_o), 64'd0);

    // errors
    chk("err_before", 64'(error_o), 64'd0);
    commit_valid_i = 1'b1; commit_id_i = 4'd7;
    cyc(); idle();
    chk("err_stray_commit", 64'(error_o), 64'd1);
    issue(4'd5, 32'h55); cyc(); idle();
    register_valid_i = 1'b1; register_id_i = 4'd5;
    register_rs_i = 64'h5; register_rs_valid_i = 2'b01;
    #1 chk("err_partial_rdy", 64'(register_ready_o), 64'd0);
    cyc();
    chk("err_partial_hold", 64'(register_ready_o), 64'd0);
    register_rs_valid_i = 2'b11;
    commit_valid_i = 1'b1; commit_id_i = 4'd5;
    #1 chk("err_full_rdy", 64'(register_ready_o), 64'd1);
    cyc(); idle();
    chk("err_dispatch_id", 64'(ex_id_o), 64'd5);
    drain("err_drain");

    // reset mid-operation
    ex_ready_i = 1'b0;
    for (int i = 1; i < 4; i++) begin issue(4'(i), 32'h200 + 32'(i)); cyc(); end
    idle();
    for (int i = 1; i < 4; i++) begin reg_cmt(4'(i)); cyc(); end
    idle();
    chk("mid_occ3", 64'(occupancy_o), 64'd3);
    chk("mid_exv", 64'(ex_valid_o), 64'd1);
    chk("mid_err_sticky", 64'(error_o), 64'd1);
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    #1;
    chk("mid_rst_occ", 64'(occupancy_o), 64'd0);
    chk("mid_rst_exv", 64'(ex_valid_o), 64'd0);
    chk("mid_rst_err", 64'(error_o), 64'd0);
    ex_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mid_no_dispatch", 64'(ex_valid_o), 64'd0);
    end
    chk("mid_occ_final", 64'(occupancy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
